// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs samples DELAY apart,
// emits rounded/saturated half-sums in the butterfly phase and stored half-differences in the fill phase.
module r2sdf_butterfly #(
  parameter int DELAY = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] Re_in,
  input  logic signed [15:0] Im_in,
  output logic               out_valid,
  output logic               out_sop,
  output logic signed [15:0] Re_out,
  output logic signed [15:0] Im_out
);

  localparam int CW = $clog2(2 * DELAY);

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          butterfly;
  logic          sop_d;
  cplx_t         dl_q [DELAY];
  cplx_t         head;
  cplx_t         in_c;
  cplx_t         wr_d;
  cplx_t         out_d;

  // (a +/- b + 1) >>> 1 with 18-bit headroom; only 32767 - (-32768) can leave the 16-bit range.
  function automatic logic signed [15:0] half_round_sat(input logic signed [15:0] a,
                                                         input logic signed [15:0] b,
                                                         input logic               sub);
    logic signed [17:0] s;
    s = sub ? ({{2{a[15]}}, a} - {{2{b[15]}}, b}) : ({{2{a[15]}}, a} + {{2{b[15]}}, b});
    s = (s + 18'sd1) >>> 1;
    if (s > 18'sd32767)       half_round_sat = 16'sh7fff;
    else if (s < -18'sd32768) half_round_sat = 16'sh8000;
    else                      half_round_sat = s[15:0];
  endfunction

  // 2*DELAY is a power of two, so cnt >= DELAY is exactly the counter MSB.
  assign butterfly = cnt_q[CW-1];
  assign head      = dl_q[DELAY-1];
  assign in_c      = '{re: Re_in, im: Im_in};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    out_d    = head;
    wr_d     = in_c;
    cnt_d    = cnt_q + CW'(1);
    primed_d = primed_q | (cnt_q == CW'(DELAY - 1));
    sop_d    = (cnt_q == CW'(DELAY));
    if (butterfly) begin
      out_d.re = half_round_sat(head.re, in_c.re, 1'b0);
      out_d.im = half_round_sat(head.im, in_c.im, 1'b0);
      wr_d.re  = half_round_sat(head.re, in_c.re, 1'b1);
      wr_d.im  = half_round_sat(head.im, in_c.im, 1'b1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      Re_out    <= '0;
      Im_out    <= '0;
    end else begin
      out_valid <= in_valid & primed_q;
      out_sop   <= in_valid & sop_d;
      if (in_valid) begin
        cnt_q    <= cnt_d;
        primed_q <= primed_d;
        Re_out   <= out_d.re;
        Im_out   <= out_d.im;
      end
    end
  end

  // NOTE: the delay line is storage, not control state; it is left unreset because
  // primed keeps its contents from ever reaching a valid output before being written.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      dl_q[0] <= wr_d;
      for (int i = 1; i < DELAY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

endmodule

// File: tb/tb_r2sdf_butterfly.sv
// Directed and reference-model checks of r2sdf_butterfly at DELAY = 1, 2, 4 and 8.
module tb_r2sdf_butterfly;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] re_in = '0;
  logic signed [15:0] im_in = '0;

  logic d1_v, d1_s, d2_v, d2_s, d4_v, d4_s, d8_v, d8_s;
  logic signed [15:0] d1_re, d1_im, d2_re, d2_im, d4_re, d4_im, d8_re, d8_im;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  r2sdf_butterfly #(.DELAY(1)) u_d1 (.clk(clk), .rst(rst), .in_valid(in_valid), .Re_in(re_in), .Im_in(im_in),
    .out_valid(d1_v), .out_sop(d1_s), .Re_out(d1_re), .Im_out(d1_im));
  r2sdf_butterfly #(.DELAY(2)) u_d2 (.clk(clk), .rst(rst), .in_valid(in_valid), .Re_in(re_in), .Im_in(im_in),
    .out_valid(d2_v), .out_sop(d2_s), .Re_out(d2_re), .Im_out(d2_im));
  r2sdf_butterfly #(.DELAY(4)) u_d4 (.clk(clk), .rst(rst), .in_valid(in_valid), .Re_in(re_in), .Im_in(im_in),
    .out_valid(d4_v), .out_sop(d4_s), .Re_out(d4_re), .Im_out(d4_im));
  r2sdf_butterfly #(.DELAY(8)) u_d8 (.clk(clk), .rst(rst), .in_valid(in_valid), .Re_in(re_in), .Im_in(im_in),
    .out_valid(d8_v), .out_sop(d8_s), .Re_out(d8_re), .Im_out(d8_im));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  // Drive one cycle of input, then sample outputs 1 ns after the edge.
  task automatic step(input logic v, input int re, input int im);
    in_valid = v;
    re_in    = 16'(re);
    im_in    = 16'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, 0);
    rst = 1'b0;
  endtask

  // Floor-division form of (a +/- b + 1) >>> 1, then clamp.
  function automatic int ref_bf(input int a, input int b, input bit sub);
    int s;
    s = (sub ? a - b : a + b) + 1;
    s = (s >= 0) ? s / 2 : -((-s + 1) / 2);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  int  t1_in  [6] = '{100, 200, 300, 400, 0, 0};
  int  t1_re  [6] = '{0, 0, 200, 300, -100, -100};
  bit  t1_v   [6] = '{0, 0, 1, 1, 1, 1};
  bit  t1_sop [6] = '{0, 0, 1, 0, 0, 0};

  int  sat_re [6] = '{32767, 0, -32768, 0, 0, 0};
  int  sat_im [6] = '{-32768, 0, -32768, 0, 0, 0};
  int  sat_ere[4] = '{0, 0, 32767, 0};
  int  sat_eim[4] = '{-32768, 0, 0, 0};

  int  rs_in  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
  int  rs_exp [12] = '{0, 0, 0, 0, 3, 4, 5, 6, -2, -2, -2, -2};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    do_reset();
    check("rst_d2_v", d2_v, 0);
    check("rst_d2_sop", d2_s, 0);
    check("rst_d2_re", d2_re, 0);
    check("rst_d2_im", d2_im, 0);
    check("rst_d8_v", d8_v, 0);

    // Basic stream, DELAY=2.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, t1_in[i], 0);
      check($sformatf("basic_v%0d", i), d2_v, 32'(t1_v[i]));
      check($sformatf("basic_sop%0d", i), d2_s, 32'(t1_sop[i]));
      if (t1_v[i]) begin
        check($sformatf("basic_re%0d", i), d2_re, t1_re[i]);
        check($sformatf("basic_im%0d", i), d2_im, 0);
      end
    end

    // Saturation and negative-rounding extremes, DELAY=2.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, sat_re[i], sat_im[i]);
      check($sformatf("sat_v%0d", i), d2_v, (i >= 2) ? 1 : 0);
      if (i >= 2) begin
        check($sformatf("sat_re%0d", i), d2_re, sat_ere[i-2]);
        check($sformatf("sat_im%0d", i), d2_im, sat_eim[i-2]);
      end
    end

    // Rounding, DELAY=1.
    do_reset();
    step(1'b1, 3, 0);
    check("rnd_pos_v0", d1_v, 0);
    step(1'b1, 0, 0);
    check("rnd_pos_sum_v", d1_v, 1);
    check("rnd_pos_sum_sop", d1_s, 1);
    check("rnd_pos_sum", d1_re, 2);
    step(1'b1, 0, 0);
    check("rnd_pos_diff_sop", d1_s, 0);
    check("rnd_pos_diff", d1_re, 2);
    do_reset();
    step(1'b1, -3, 0);
    step(1'b1, 0, 0);
    check("rnd_neg_sum", d1_re, -1);
    step(1'b1, 0, 0);
    check("rnd_neg_diff_v", d1_v, 1);
    check("rnd_neg_diff", d1_re, -1);

    // Gapped stream, DELAY=2: idle cycles drop valid/sop and hold data.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, t1_in[i], 0);
      check($sformatf("gap_v%0d", i), d2_v, 32'(t1_v[i]));
      check($sformatf("gap_sop%0d", i), d2_s, 32'(t1_sop[i]));
      if (t1_v[i]) check($sformatf("gap_re%0d", i), d2_re, t1_re[i]);
      step(1'b0, 12345, 0);
      check($sformatf("gap_idle_v%0d", i), d2_v, 0);
      check($sformatf("gap_idle_sop%0d", i), d2_s, 0);
      if (t1_v[i]) check($sformatf("gap_hold_re%0d", i), d2_re, t1_re[i]);
    end

    // Reset mid-block, DELAY=4.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 10 * (i + 1), 7);
      if (i == 4) check("mid_pre_sop", d4_s, 1);
    end
    rst = 1'b1;
    step(1'b1, 999, 999);
    rst = 1'b0;
    check("mid_rst_v", d4_v, 0);
    check("mid_rst_sop", d4_s, 0);
    check("mid_rst_re", d4_re, 0);
    check("mid_rst_im", d4_im, 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, rs_in[i], 0);
      check($sformatf("mid_v%0d", i), d4_v, (i >= 4) ? 1 : 0);
      check($sformatf("mid_sop%0d", i), d4_s, (i == 4) ? 1 : 0);
      if (i >= 4) check($sformatf("mid_re%0d", i), d4_re, rs_exp[i]);
    end

    // Random stream, DELAY=8, against a reference model.
    do_reset();
    begin
      int m_re [8];
      int m_im [8];
      int cnt = 0;
      bit primed = 0;
      int xr, xi, er, ei, wr, wi;
      bit ev, es;
      for (int i = 0; i < 8; i++) begin m_re[i] = 0; m_im[i] = 0; end
      for (int n = 0; n < 1000; n++) begin
        case ($urandom_range(0, 9))
          0:       xr = 32767;
          1:       xr = -32768;
          default: xr = int'($signed(16'($urandom)));
        endcase
        case ($urandom_range(0, 9))
          0:       xi = 32767;
          1:       xi = -32768;
          default: xi = int'($signed(16'($urandom)));
        endcase
        if (cnt < 8) begin
          er = m_re[7]; ei = m_im[7]; wr = xr; wi = xi;
        end else begin
          er = ref_bf(m_re[7], xr, 0); ei = ref_bf(m_im[7], xi, 0);
          wr = ref_bf(m_re[7], xr, 1); wi = ref_bf(m_im[7], xi, 1);
        end
        for (int k = 7; k > 0; k--) begin m_re[k] = m_re[k-1]; m_im[k] = m_im[k-1]; end
        m_re[0] = wr; m_im[0] = wi;
        ev = primed;
        es = (cnt == 8);
        if (cnt == 7) primed = 1;
        cnt = (cnt + 1) % 16;
        step(1'b1, xr, xi);
        check($sformatf("rand_v%0d", n), d8_v, 32'(ev));
        check($sformatf("rand_sop%0d", n), d8_s, 32'(es));
        if (ev) begin
          check($sformatf("rand_re%0d", n), d8_re, er);
          check($sformatf("rand_im%0d", n), d8_im, ei);
        end
      end
    end

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
